// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants, types and helpers for the PS/2 receive sequencer.
//   - Scan-code prefix and control byte values seen on the keyboard link.
//   - Decoder state encoding.
//   - key_event_t: one decoded key event {code, extended, release}.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_BAT_E0 = 8'hFC;
    localparam logic [7:0] PS2_BAT_E1 = 8'hFD;
    localparam logic [7:0] PS2_OVR0   = 8'h00;
    localparam logic [7:0] PS2_OVR1   = 8'hFF;

    typedef enum logic [1:0] {
        D_IDLE    = 2'd0,
        D_EXT     = 2'd1,
        D_BRK     = 2'd2,
        D_EXT_BRK = 2'd3
    } dec_state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       rel;
    } key_event_t;

    // Keyboard buffer-overrun indications.
    function automatic logic is_overrun(input logic [7:0] b);
        return (b == PS2_OVR0) || (b == PS2_OVR1);
    endfunction

    // Keyboard status/response bytes that are not key codes.
    function automatic logic is_discard(input logic [7:0] b);
        return (b == PS2_BAT_OK) || (b == PS2_ACK) || (b == PS2_ECHO) ||
               (b == PS2_BAT_E0) || (b == PS2_BAT_E1);
    endfunction

endpackage

// File: rtl/ps2_frame_watchdog.sv
// ps2_frame_watchdog: per-frame PS/2 clock watchdog.
//   Counts PS/2 clock edges within a frame and the system cycles between
//   them; a stalled frame or one with too many edges is flushed.
// Ports:
//   clk, rst_n            system clock, async active-low reset
//   ps2_clk_posedge       single-cycle PS/2 clock rising-edge pulse
//   rx_data_strb          byte-valid pulse from the receiver (ends a frame)
//   flush_cond            combinational: a flush happens at the next edge
//   rx_flush              registered single-cycle flush pulse
//   start_receiving_data  registered arm signal, low only in the flush cycle
module ps2_frame_watchdog #(
    parameter int TIMEOUT_CYCLES  = 20000,
    parameter int MAX_FRAME_EDGES = 11
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk_posedge,
    input  logic rx_data_strb,
    output logic flush_cond,
    output logic rx_flush,
    output logic start_receiving_data
);

    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [3:0]      edge_cnt;
    logic [WD_W-1:0] wd_cnt;
    logic            wd_hit;
    logic            too_many_edges;

    // The watchdog only matters while a frame is in progress; between frames
    // wd_cnt is frozen and must not trigger a flush.
    assign wd_hit         = (edge_cnt != 4'd0) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign too_many_edges = ps2_clk_posedge && (edge_cnt >= 4'(MAX_FRAME_EDGES));
    // A completed byte in the same cycle ends the frame cleanly and wins.
    assign flush_cond     = !rx_data_strb && (wd_hit || too_many_edges);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt             <= 4'd0;
            wd_cnt               <= '0;
            rx_flush             <= 1'b0;
            start_receiving_data <= 1'b0;
        end else begin
            rx_flush             <= flush_cond;
            start_receiving_data <= !flush_cond;

            if (flush_cond || rx_data_strb) begin
                edge_cnt <= 4'd0;
            end else if (ps2_clk_posedge) begin
                edge_cnt <= edge_cnt + 4'd1;
            end

            if (flush_cond || rx_data_strb || ps2_clk_posedge) begin
                wd_cnt <= '0;
            end else if (edge_cnt != 4'd0 && wd_cnt != '1) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_rx_sequencer.sv
// ps2_rx_sequencer: PS/2 scan-code sequencer between the byte receiver and
// the Morse encoding path.
//   - Arms the receiver and flushes stalled/over-long frames (watchdog).
//   - Decodes E0 (extended) and F0 (break) prefixes into single key events.
//   - Presents events through a one-entry valid/ready output register.
// Optional feature: define PS2_TYPEMATIC_FILTER_EN to suppress repeated make
// events of the most recently pressed key (typematic repeat).
// Ports:
//   clk, rst_n                       system clock, async active-low reset
//   ps2_clk_posedge                  PS/2 clock rising-edge pulse
//   rx_data, rx_data_strb            received byte and its valid pulse
//   start_receiving_data, rx_flush   receiver arm / flush controls
//   key_code, key_extended,
//   key_release, key_valid, key_ready event output handshake
//   err_clr                          clears the sticky error flags
//   err_timeout, err_overrun,
//   err_drop                         sticky error flags
module ps2_rx_sequencer
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES  = 20000,
    parameter int MAX_FRAME_EDGES = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk_posedge,
    input  logic [7:0] rx_data,
    input  logic       rx_data_strb,
    output logic       start_receiving_data,
    output logic       rx_flush,
    output logic [7:0] key_code,
    output logic       key_extended,
    output logic       key_release,
    output logic       key_valid,
    input  logic       key_ready,
    input  logic       err_clr,
    output logic       err_timeout,
    output logic       err_overrun,
    output logic       err_drop
);

    logic       flush_cond;
    dec_state_t dec_state, dec_next;
    key_event_t ev;
    logic       emit_raw;
    logic       emit;
    logic       ovr_set;
    logic       load;
    logic       drop;

    ps2_frame_watchdog #(
        .TIMEOUT_CYCLES  (TIMEOUT_CYCLES),
        .MAX_FRAME_EDGES (MAX_FRAME_EDGES)
    ) u_watchdog (
        .clk                  (clk),
        .rst_n                (rst_n),
        .ps2_clk_posedge      (ps2_clk_posedge),
        .rx_data_strb         (rx_data_strb),
        .flush_cond           (flush_cond),
        .rx_flush             (rx_flush),
        .start_receiving_data (start_receiving_data)
    );

    // Prefix decoder: advances only on a received byte.
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        dec_next = dec_state;
        ev       = '0;
        emit_raw = 1'b0;
        ovr_set  = 1'b0;
        if (rx_data_strb) begin
            ev.code = rx_data;
            if (is_overrun(rx_data)) begin
                ovr_set  = 1'b1;
                dec_next = D_IDLE;
            end else begin
                case (dec_state)
                    D_IDLE: begin
                        if (rx_data == PS2_EXT) begin
                            dec_next = D_EXT;
                        end else if (rx_data == PS2_BRK) begin
                            dec_next = D_BRK;
                        end else if (!is_discard(rx_data)) begin
                            emit_raw = 1'b1;
                        end
                    end
                    D_EXT: begin
                        if (rx_data == PS2_BRK) begin
                            dec_next = D_EXT_BRK;
                        end else if (rx_data != PS2_EXT) begin
                            emit_raw = 1'b1;
                            ev.ext   = 1'b1;
                            dec_next = D_IDLE;
                        end
                    end
                    D_BRK: begin
                        emit_raw = 1'b1;
                        ev.rel   = 1'b1;
                        dec_next = D_IDLE;
                    end
                    default: begin // D_EXT_BRK
                        emit_raw = 1'b1;
                        ev.ext   = 1'b1;
                        ev.rel   = 1'b1;
                        dec_next = D_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic       lm_valid;
    logic [7:0] lm_code;
    logic       lm_ext;
    logic       lm_match;

    assign lm_match = lm_valid && (lm_code == ev.code) && (lm_ext == ev.ext);
    // A make identical to the last make is an auto-repeat and is suppressed.
    assign emit     = emit_raw && !(lm_match && !ev.rel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lm_valid <= 1'b0;
            lm_code  <= 8'h00;
            lm_ext   <= 1'b0;
        end else if (flush_cond) begin
            lm_valid <= 1'b0;
        end else if (emit_raw) begin
            if (!ev.rel) begin
                lm_valid <= 1'b1;
                lm_code  <= ev.code;
                lm_ext   <= ev.ext;
            end else if (lm_match) begin
                lm_valid <= 1'b0;
            end
        end
    end
`else
    assign emit = emit_raw;
`endif

    assign load = emit && (!key_valid || key_ready);
    assign drop = emit && key_valid && !key_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_state    <= D_IDLE;
            key_code     <= 8'h00;
            key_extended <= 1'b0;
            key_release  <= 1'b0;
            key_valid    <= 1'b0;
            err_timeout  <= 1'b0;
            err_overrun  <= 1'b0;
            err_drop     <= 1'b0;
        end else begin
            // A flush never coincides with a byte, so it simply resets the prefix.
            dec_state <= flush_cond ? D_IDLE : dec_next;

            if (load) begin
                key_code     <= ev.code;
                key_extended <= ev.ext;
                key_release  <= ev.rel;
                key_valid    <= 1'b1;
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end

            // Sticky flags: a new set event beats a simultaneous clear.
            err_timeout <= flush_cond | (err_timeout & ~err_clr);
            err_overrun <= ovr_set    | (err_overrun & ~err_clr);
            err_drop    <= drop       | (err_drop    & ~err_clr);
        end
    end

endmodule

// File: doc/ps2_rx_sequencer.md
Name: ps2_rx_sequencer

Overview:
- Sits between the PS/2 byte receiver and the Morse encoding path.
- Arms the byte receiver and watches PS/2 clock activity with a per-frame watchdog; stalled or over-long frames are flushed.
- Decodes the scan-code prefix bytes (E0 extended, F0 break) and turns received bytes into single key events.
- Key events leave through a one-entry valid/ready output register.

Parameters:
- TIMEOUT_CYCLES, 20000, clk cycles allowed between consecutive ps2_clk_posedge pulses within a frame (2 ms at 10 MHz).
- MAX_FRAME_EDGES, 11, ps2_clk_posedge pulses allowed per frame before it is declared a framing error.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ps2_clk_posedge  in  1  single-cycle PS/2 clock rising-edge pulse
- rx_data  in  8  byte from receiver
- rx_data_strb  in  1  single-cycle byte-valid pulse from receiver
- start_receiving_data  out  1  arms the receiver
- rx_flush  out  1  single-cycle pulse, ORed into the receiver's reset
- key_code  out  8  scan code of the event
- key_extended  out  1  event was E0-prefixed
- key_release  out  1  event was F0-prefixed (break)
- key_valid  out  1  event available
- key_ready  in  1  consumer accepts the event
- err_clr  in  1  clears the sticky error flags
- err_timeout  out  1  sticky: watchdog or framing flush occurred
- err_overrun  out  1  sticky: keyboard sent 0x00 or 0xFF
- err_drop  out  1  sticky: event lost because the output register was full

Behaviour:
- Reset values:
  - All outputs 0, except start_receiving_data, which is 1 from the first clock after reset release.
  - Decoder state is D_IDLE, all counters are 0.
- Frame tracker:
  - edge_cnt (4 bit) increments on each ps2_clk_posedge and clears on rx_data_strb.
  - wd_cnt clears on each ps2_clk_posedge and otherwise increments while edge_cnt != 0, saturating.
  - Flush condition: wd_cnt reaches TIMEOUT_CYCLES-1, or edge_cnt would exceed MAX_FRAME_EDGES.
  - Next cycle after the flush condition:
    - rx_flush=1 for exactly one cycle.
    - start_receiving_data=0 in that same cycle.
    - edge_cnt and wd_cnt clear; decoder returns to D_IDLE.
    - err_timeout sets.
  - rx_data_strb in the same cycle as the flush condition: the strobe wins and no flush happens.
- Decoder FSM (advances only on rx_data_strb):
  - D_IDLE:
    - E0 goes to D_EXT.
    - F0 goes to D_BRK.
    - 00 or FF: set err_overrun, stay in D_IDLE.
    - AA, FA, EE, FC, FD: discarded, stay in D_IDLE.
    - Any other byte: emit {code, ext=0, rel=0}.
  - D_EXT:
    - F0 goes to D_EXT_BRK.
    - E0 stays in D_EXT.
    - 00 or FF: set err_overrun, return to D_IDLE.
    - Any other byte: emit {code, ext=1, rel=0}, return to D_IDLE.
  - D_BRK:
    - 00 or FF: set err_overrun, return to D_IDLE.
    - Any other byte (including E0 and F0): emit {code, ext=0, rel=1}, return to D_IDLE.
  - D_EXT_BRK:
    - 00 or FF: set err_overrun, return to D_IDLE.
    - Any other byte: emit {code, ext=1, rel=1}, return to D_IDLE.
- Output register:
  - Emit when key_valid=0: load key_code/key_extended/key_release and set key_valid on the next cycle (1-cycle latency from rx_data_strb).
  - key_valid && key_ready: key_valid clears next cycle.
  - Emit in the same cycle as key_valid && key_ready: the new event loads and key_valid stays 1.
  - Emit while key_valid && !key_ready: the new event is dropped, the held event is kept, err_drop sets.
- Error flags: sticky. err_clr clears them next cycle; a set event in the same cycle as err_clr wins (flag stays 1).
- start_receiving_data: 1 in every cycle except the rx_flush cycle.
- Reset mid-frame or mid-prefix: all state is discarded immediately (asynchronous) and no event is emitted.

Optional Feature:
- Macro PS2_TYPEMATIC_FILTER_EN.
- Defined:
  - Keeps last_make {code, ext}.
  - A make event equal to last_make is suppressed (typematic repeat).
  - A break event whose {code, ext} matches last_make clears last_make.
  - Reset and flush clear last_make.
- Undefined: every make is emitted and no last_make register exists.

Decomposition:
- Package ps2_pkg:
  - Byte constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_BAT_OK=8'hAA, PS2_ACK=8'hFA, PS2_ECHO=8'hEE, PS2_OVR0=8'h00, PS2_OVR1=8'hFF.
  - Decoder state encoding D_IDLE=2'd0, D_EXT=2'd1, D_BRK=2'd2, D_EXT_BRK=2'd3.
- One sub-module: ps2_frame_watchdog, containing edge_cnt, wd_cnt and flush generation.
- The decoder FSM and output register live in the top module.

Test Plan:
- Strobe 1C with key_ready=1 -> key_valid one cycle later with code=1C, ext=0, rel=0; clears the cycle after.
- Strobes E0, F0, 75 -> exactly one event: code=75, ext=1, rel=1; no event on E0 or F0.
- 3 edges then silence for TIMEOUT_CYCLES -> single-cycle rx_flush, err_timeout=1, decoder back in D_IDLE; following strobe 1C emits rel=0.
- key_ready=0, strobes 1C then 32 -> key_code stays 1C, err_drop=1; after key_ready=1 no 32 event appears; err_clr clears err_drop.
- Strobes FF and AA -> err_overrun=1, no events.
- With PS2_TYPEMATIC_FILTER_EN defined: 1C, 1C, 1C, F0, 1C, 1C -> events are make 1C, break 1C, make 1C only.
